// File: rtl/xvc_bscan_pkg.sv
// Shared types, default constants and the IEEE 1149.1 TAP next-state function
// for the XVC BSCAN master.
package xvc_bscan_pkg;

  localparam int unsigned MAX_LEN_DEF = 32;
  localparam int unsigned CLK_DIV_DEF = 4;
  localparam int unsigned LEN_W       = 6;
  localparam int unsigned LEN_X       = LEN_W + 1;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_RESP
  } xvc_state_t;

  // TAP controller transition on one TCK rise with the given TMS.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Shadow TAP controller: follows the TMS stream on each TCK rise and
// presents registered decodes of the states the BSCAN consumer cares about.
module jtag_tap_tracker
  import xvc_bscan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       tms,
  output tap_state_t state,
  output logic       shift,
  output logic       capture,
  output logic       update,
  output logic       runtest,
  output logic       reset
);

  tap_state_t state_d;

  assign state_d = advance ? tap_next(state, tms) : state;

  // Decodes are taken from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TEST_LOGIC_RESET;
      shift   <= 1'b0;
      capture <= 1'b0;
      update  <= 1'b0;
      runtest <= 1'b0;
      reset   <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= (state_d == SHIFT_DR);
      capture <= (state_d == CAPTURE_DR);
      update  <= (state_d == UPDATE_DR);
      runtest <= (state_d == RUN_TEST_IDLE);
      reset   <= (state_d == TEST_LOGIC_RESET);
    end
  end

endmodule

// File: rtl/xvc_bscan_master.sv
// XVC shift-command engine driving a BSCAN master port into a PR region.
// Define XVC_TAP_TRACK_EN to build in the TAP tracker and its state decodes.
module xvc_bscan_master
  import xvc_bscan_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_tms,
  input  logic [MAX_LEN-1:0] cmd_tdi,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_tdo,
  input  logic               sel_en,
  output logic               M_BSCAN_tck,
  output logic               M_BSCAN_tms,
  output logic               M_BSCAN_tdi,
  output logic               M_BSCAN_drck,
  output logic               M_BSCAN_sel,
  output logic               M_BSCAN_shift,
  output logic               M_BSCAN_capture,
  output logic               M_BSCAN_update,
  output logic               M_BSCAN_runtest,
  output logic               M_BSCAN_reset,
  output logic               M_BSCAN_bscanid_en,
  input  logic               M_BSCAN_tdo
);

  xvc_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_q;
  logic [MAX_LEN-1:0] tms_sr_q;
  logic [MAX_LEN-1:0] tdi_sr_q;
  logic [MAX_LEN-1:0] tdo_q;
  logic               tck_q;
  logic               tms_q;
  logic               tdi_q;
  logic               sel_q;
  logic               drck_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;

  logic               div_end_c;
  logic               last_bit_c;
  logic [LEN_W-1:0]   len_clamp_c;
  logic               tck_d;
  logic               dr_d;

  assign div_end_c   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_bit_c  = (LEN_X'(bit_q) + LEN_X'(1)) >= LEN_X'(len_q);
  assign len_clamp_c = (32'(cmd_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;

  // TCK level the state register is about to take; drck is built from it.
  always_comb begin
    tck_d = 1'b0;
    case (state_q)
      ST_LOW:  tck_d = div_end_c;
      ST_HIGH: tck_d = !div_end_c;
      default: tck_d = 1'b0;
    endcase
  end

`ifdef XVC_TAP_TRACK_EN
  tap_state_t tap_state;
  tap_state_t tap_nxt_c;
  logic       advance_c;

  assign advance_c = (state_q == ST_LOW) && div_end_c;
  assign tap_nxt_c = advance_c ? tap_next(tap_state, tms_q) : tap_state;
  assign dr_d      = (tap_nxt_c == SHIFT_DR) || (tap_nxt_c == CAPTURE_DR);

  jtag_tap_tracker u_tap (
    .clk     (clk),
    .rst     (rst),
    .advance (advance_c),
    .tms     (tms_q),
    .state   (tap_state),
    .shift   (M_BSCAN_shift),
    .capture (M_BSCAN_capture),
    .update  (M_BSCAN_update),
    .runtest (M_BSCAN_runtest),
    .reset   (M_BSCAN_reset)
  );
`else
  assign dr_d            = 1'b1;
  assign M_BSCAN_shift   = 1'b0;
  assign M_BSCAN_capture = 1'b0;
  assign M_BSCAN_update  = 1'b0;
  assign M_BSCAN_runtest = 1'b0;
  assign M_BSCAN_reset   = 1'b0;
`endif

  // Command sequencer: one LOW and one HIGH phase of CLK_DIV cycles per bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      bit_q       <= '0;
      tms_sr_q    <= '0;
      tdi_sr_q    <= '0;
      tdo_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      tck_q <= tck_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q       <= len_clamp_c;
            bit_q       <= '0;
            cnt_q       <= '0;
            tdo_q       <= '0;
            tms_q       <= cmd_tms[0];
            tdi_q       <= cmd_tdi[0];
            tms_sr_q    <= cmd_tms >> 1;
            tdi_sr_q    <= cmd_tdi >> 1;
            cmd_ready_q <= 1'b0;
            if (len_clamp_c == '0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (div_end_c) begin
            cnt_q   <= '0;
            state_q <= ST_HIGH;
            tdo_q   <= tdo_q | (MAX_LEN'(M_BSCAN_tdo) << bit_q);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (div_end_c) begin
            cnt_q <= '0;
            if (last_bit_c) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q  <= ST_LOW;
              bit_q    <= bit_q + LEN_W'(1);
              tms_q    <= tms_sr_q[0];
              tdi_q    <= tdi_sr_q[0];
              tms_sr_q <= tms_sr_q >> 1;
              tdi_sr_q <= tdi_sr_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= 1'b0;
      drck_q <= 1'b0;
    end else begin
      sel_q  <= sel_en;
      drck_q <= tck_d & sel_en & dr_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_tdo            = tdo_q;
  assign M_BSCAN_tck        = tck_q;
  assign M_BSCAN_tms        = tms_q;
  assign M_BSCAN_tdi        = tdi_q;
  assign M_BSCAN_sel        = sel_q;
  assign M_BSCAN_drck       = drck_q;
  assign M_BSCAN_bscanid_en = 1'b0;

endmodule

// File: tb/tb_xvc_bscan_master.sv
// Self-checking bench for xvc_bscan_master: vector table, TAP scenarios,
// random commands against a bit-level model, and a mid-command reset.
module tb_xvc_bscan_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned MAX_LEN = 32;
`ifdef XVC_TAP_TRACK_EN
  localparam logic TRACK = 1'b1;
`else
  localparam logic TRACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, sel_en;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms, cmd_tdi, rsp_tdo;
  logic        b_tck, b_tms, b_tdi, b_drck, b_sel, b_shift, b_capture;
  logic        b_update, b_runtest, b_reset, b_idn, b_tdo;
  logic        tdo_inv;

  int checks = 0;
  int failures = 0;

  assign b_tdo = b_tdi ^ tdo_inv;
  always #5 clk = ~clk;

  xvc_bscan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
    .sel_en(sel_en),
    .M_BSCAN_tck(b_tck), .M_BSCAN_tms(b_tms), .M_BSCAN_tdi(b_tdi),
    .M_BSCAN_drck(b_drck), .M_BSCAN_sel(b_sel), .M_BSCAN_shift(b_shift),
    .M_BSCAN_capture(b_capture), .M_BSCAN_update(b_update),
    .M_BSCAN_runtest(b_runtest), .M_BSCAN_reset(b_reset),
    .M_BSCAN_bscanid_en(b_idn), .M_BSCAN_tdo(b_tdo)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // IEEE 1149.1 graph as lookup tables: 0=TLR 1=RTI 3=CAPTURE_DR 4=SHIFT_DR 8=UPDATE_DR.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int   tap_m = 0;
  logic exp_tms_q[$];
  logic exp_tdi_q[$];
  int   rise_cnt = 0;
  int   drck_rise_cnt = 0;
  logic prev_tck = 1'b0;
  logic prev_drck = 1'b0;
  logic sel_lat;
  logic tms_m, tdi_m, dr_m;
  logic [7:0] exp_v, act_v;

  always @(posedge clk or posedge rst) begin
    if (rst) sel_lat <= 1'b0;
    else     sel_lat <= sel_en;
  end

  // Port monitor: bit order at each TCK rise, TAP decodes, sel and drck every cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_tms_q.delete();
      exp_tdi_q.delete();
      tap_m     = 0;
      prev_tck  = 1'b0;
      prev_drck = 1'b0;
    end else begin
      if (b_tck && !prev_tck) begin
        rise_cnt++;
        check("tck_rise_expected", 64'(exp_tms_q.size() != 0), 64'(1));
        if (exp_tms_q.size() != 0) begin
          tms_m = exp_tms_q.pop_front();
          tdi_m = exp_tdi_q.pop_front();
          check("tms_tdi_at_rise", 64'({b_tms, b_tdi}), 64'({tms_m, tdi_m}));
          tap_m = tms_m ? nxt1[tap_m] : nxt0[tap_m];
        end
      end
      if (b_drck && !prev_drck) drck_rise_cnt++;
      prev_tck  = b_tck;
      prev_drck = b_drck;
    end
    dr_m  = (tap_m == 4) || (tap_m == 3);
    exp_v = {b_tck & sel_lat & (TRACK ? dr_m : 1'b1), sel_lat,
             TRACK & (tap_m == 4), TRACK & (tap_m == 3), TRACK & (tap_m == 8),
             TRACK & (tap_m == 1), TRACK & (tap_m == 0), 1'b0};
    act_v = {b_drck, b_sel, b_shift, b_capture, b_update, b_runtest, b_reset, b_idn};
    check("bscan_decodes", 64'(act_v), 64'(exp_v));
  end

  task automatic run_cmd(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                         input logic inv, input int hold, input logic [31:0] exp_tdo,
                         input int exp_rises, input string nm);
    int r0, lat;
    @(negedge clk);
    check({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    tdo_inv   = inv;
    cmd_valid = 1'b1;
    cmd_len   = 6'(len);
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    for (int k = 0; k < exp_rises; k++) begin
      exp_tms_q.push_back(tms[k]);
      exp_tdi_q.push_back(tdi[k]);
    end
    r0 = rise_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 700) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat),
          64'((exp_rises == 0) ? 1 : 2 * int'(CLK_DIV) * exp_rises + 1));
    check({nm, "_rsp_tdo"}, 64'(rsp_tdo), 64'(exp_tdo));
    check({nm, "_tck_rises"}, 64'(rise_cnt - r0), 64'(exp_rises));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({nm, "_backpressure"}, 64'({rsp_valid, cmd_ready, rsp_tdo}),
            64'({1'b1, 1'b0, exp_tdo}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, "_after_handshake"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  typedef struct {
    int          len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic        inv;
    int          hold;
    logic [31:0] exp_tdo;
    int          exp_rises;
  } vec_t;

  vec_t vt[8];

  initial begin
    int   r0, d0, n;
    logic bad;
    vt[0] = '{8,  32'h0000_0006, 32'h0000_00A5, 1'b0, 10, 32'h0000_00A5, 8};
    vt[1] = '{0,  32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2,  32'h0000_0000, 0};
    vt[2] = '{40, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1,  32'hFFFF_FFFF, 32};
    vt[3] = '{1,  32'h0000_0000, 32'h0000_0001, 1'b0, 0,  32'h0000_0001, 1};
    vt[4] = '{32, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 3,  32'h2152_4110, 32};
    vt[5] = '{5,  32'h0000_0000, 32'h0000_00FF, 1'b0, 0,  32'h0000_001F, 5};
    vt[6] = '{31, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1,  32'h7FFF_FFFF, 31};
    vt[7] = '{63, 32'h0000_0000, 32'h1234_5678, 1'b1, 0,  32'hEDCB_A987, 32};

    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; sel_en = 1'b1;
    cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; tdo_inv = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_state",
          64'({cmd_ready, rsp_valid, rsp_tdo, b_tck, b_tms, b_tdi, b_drck, b_sel}),
          64'({1'b1, 1'b0, 32'h0, 5'b00000}));
    check("reset_tap_reset", 64'(b_reset), 64'(TRACK));
    #2 rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_cmd(vt[i].len, vt[i].tms, vt[i].tdi, vt[i].inv, vt[i].hold,
              vt[i].exp_tdo, vt[i].exp_rises, $sformatf("vec%0d", i));

    // Five TMS ones reach Test-Logic-Reset from anywhere; one zero enters Run-Test/Idle.
    run_cmd(5, 32'h1F, 32'h0, 1'b0, 0, 32'h0, 5, "tap_reset");
    check("tlr_reset_decode", 64'({b_reset, b_runtest}), 64'({TRACK, 1'b0}));
    run_cmd(1, 32'h0, 32'h1, 1'b0, 0, 32'h1, 1, "tap_rti");
    check("rti_runtest_decode", 64'({b_reset, b_runtest}), 64'({1'b0, TRACK}));

    // DR scan: RTI -> SELECT_DR -> CAPTURE_DR, then shift with and without sel.
    run_cmd(4, 32'b0100, 32'h0, 1'b0, 0, 32'h0, 4, "dr_capture");
    check("capture_decode", 64'(b_capture), 64'(TRACK));
    d0 = drck_rise_cnt;
    run_cmd(4, 32'h0, 32'h9, 1'b0, 0, 32'h9, 4, "dr_shift_sel");
    check("shift_decode", 64'(b_shift), 64'(TRACK));
    check("drck_pulses_sel1", 64'(drck_rise_cnt - d0), 64'(4));
    sel_en = 1'b0;
    d0 = drck_rise_cnt;
    run_cmd(4, 32'h0, 32'h6, 1'b0, 0, 32'h6, 4, "dr_shift_nosel");
    check("drck_pulses_sel0", 64'(drck_rise_cnt - d0), 64'(0));
    sel_en = 1'b1;

    for (int t = 0; t < 25; t++) begin
      int          l, le;
      logic [31:0] tm, td;
      logic        iv;
      logic [63:0] m;
      l  = $urandom_range(0, 40);
      tm = $urandom;
      td = $urandom;
      iv = 1'($urandom_range(0, 1));
      le = (l > int'(MAX_LEN)) ? int'(MAX_LEN) : l;
      m  = (64'd1 << le) - 64'd1;
      run_cmd(l, tm, td, iv, $urandom_range(0, 4), (td ^ {32{iv}}) & m[31:0], le,
              $sformatf("rand%0d", t));
    end

    // Reset while bit 3 of a 16-bit command is being clocked.
    @(negedge clk);
    tdo_inv = 1'b0; cmd_valid = 1'b1; cmd_len = 6'd16; cmd_tms = '0; cmd_tdi = 32'h0000_BEEF;
    for (int k = 0; k < 16; k++) begin
      exp_tms_q.push_back(1'b0);
      exp_tdi_q.push_back(cmd_tdi[k]);
    end
    r0 = rise_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((rise_cnt - r0) < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_bit3", 64'(rise_cnt - r0), 64'(4));
    check("midrst_tck_before", 64'(b_tck), 64'(1));
    #2 rst = 1'b1;
    #1 check("midrst_async", 64'({b_tck, rsp_valid, cmd_ready}), 64'(3'b001));
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready || b_tck) bad = 1'b1;
    end
    check("midrst_no_response", 64'(bad), 64'(0));
    run_cmd(16, 32'h0000_0000, 32'h0000_C3A5, 1'b0, 1, 32'h0000_C3A5, 16, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
